// File: rtl/sc_param.sv
// sc_param: WIDTH-bit up/down counter bounded to 0..MAX.
// Saturates or wraps at the bounds (WRAP), supports a synchronous clear,
// a range-checked parallel load, a one-cycle boundary pulse (ovf) and an
// error flag (err) covering rejected loads and out-of-range counts.
// With WIDTH=3, MAX=5, WRAP=0, en=1, dir=1, load=0 it matches the fixed
// 3-bit saturating sequence counter it replaces.
module sc_param #(
   parameter int WIDTH = 3,
   parameter int MAX   = 5,
   parameter int WRAP  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctr_rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             ovf,
   output logic             err
);

   // Bound and constants held at counter width so every compare and
   // step stays within WIDTH-bit unsigned arithmetic.
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_W = '0;
   localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             lderr_reg;
   logic             lderr_next;

   // Values used by the step logic, split out for readability.
   logic cnt_illegal;
   logic cnt_at_max;
   logic cnt_at_zero;
   logic load_ok;

   assign cnt_illegal = (cnt_reg > MAX_W);
   assign cnt_at_max  = (cnt_reg == MAX_W);
   assign cnt_at_zero = (cnt_reg == ZERO_W);
   assign load_ok     = (load_val <= MAX_W);

   // Next-state decode: clear beats load, load beats a step, otherwise hold.
   // The pulses default low so they last one cycle unless re-triggered.
   always_comb begin
      cnt_next   = cnt_reg;
      ovf_next   = 1'b0;
      lderr_next = 1'b0;
      if (ctr_rst) begin
         cnt_next = ZERO_W;
      end else if (load) begin
         // A rejected load still consumes the cycle: the count holds and
         // any simultaneous step request is dropped.
         if (load_ok) begin
            cnt_next = load_val;
         end else begin
            lderr_next = 1'b1;
         end
      end else if (en) begin
         if (dir) begin
            if (cnt_illegal) begin
               // Recover from an out-of-range count as if wrapping,
               // independent of WRAP.
               cnt_next = ZERO_W;
               ovf_next = 1'b1;
            end else if (cnt_at_max) begin
               cnt_next = (WRAP != 0) ? ZERO_W : MAX_W;
               ovf_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + ONE_W;
            end
         end else begin
            if (cnt_illegal) begin
               // Recover downward to the top of the legal range.
               cnt_next = MAX_W;
            end else if (cnt_at_zero) begin
               cnt_next = (WRAP != 0) ? MAX_W : ZERO_W;
               ovf_next = 1'b1;
            end else begin
               cnt_next = cnt_reg - ONE_W;
            end
         end
      end
   end

   // State registers; the active-low reset also discards pending pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= ZERO_W;
         ovf_reg   <= 1'b0;
         lderr_reg <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
         lderr_reg <= lderr_next;
      end
   end

   assign out = cnt_reg;
   assign ovf = ovf_reg;
   // An out-of-range count can only come from an upset or a bad MAX/WIDTH
   // pairing; flag it continuously alongside the load-error pulse.
   assign err = lderr_reg | cnt_illegal;

endmodule
